iq_interp: RTL and testbench

Upstream I/Q sample interpolator feeding the beamformer top. Accepts signed I/Q samples at the low input rate over a valid/ready handshake and buffers them in a small FIFO. Emits one linearly interpolated I/Q pair per `clock` at 2^RATIO_LOG2 times the input rate, so the delta-sigma stages see a smooth per-clock stimulus instead of a staircase.

---
 rtl/iq_interp.sv | 166 ++++++++++++++++
 tb/tb_iq_interp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_interp.sv
// iq_interp: FIFO-buffered linear I/Q interpolator, 2^RATIO_LOG2 outputs per input sample.
// Define IQ_INTERP_ROUND_EN to use a round-half-up phase shift instead of a floor shift.
`timescale 1ns/1ps

module iq_interp #(
    parameter int DATA_W     = 10,
    parameter int RATIO_LOG2 = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic              underrun
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PROD_W = DATA_W + 1 + RATIO_LOG2;
    localparam int R      = 1 << RATIO_LOG2;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    logic [DATA_W-1:0]     memI_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     memQ_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inReady_q;
    logic                  push, pop;
    logic [DATA_W-1:0]     headI, headQ;

    state_t                state_q;
    logic [RATIO_LOG2-1:0] k_q;
    logic [DATA_W-1:0]     pI_q, nI_q, pQ_q, nQ_q;
    logic [DATA_W-1:0]     outI_q, outQ_q;
    logic                  outValid_q;
    logic                  underrun_q;

    // P + (N-P)*k / R; the result stays within [P,N], so plain truncation is safe.
    function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0]     p,
                                                 input logic [DATA_W-1:0]     n,
                                                 input logic [RATIO_LOG2-1:0] k);
        logic signed [DATA_W:0]   diff;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        diff = {n[DATA_W-1], n} - {p[DATA_W-1], p};
        prod = {{RATIO_LOG2{diff[DATA_W]}}, diff} * {{(DATA_W+1){1'b0}}, k};
`ifdef IQ_INTERP_ROUND_EN
        prod = prod + PROD_W'(R / 2);
`endif
        shifted = prod >>> RATIO_LOG2;
        return p + DATA_W'(shifted);
    endfunction

    assign push  = in_valid & inReady_q;
    assign headI = memI_q[rdPtr_q];
    assign headQ = memQ_q[rdPtr_q];

    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            case (state_q)
                IDLE, PRIME: pop = 1'b1;
                RUN:         pop = &k_q;
                default:     pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Ready is registered from the next count, so a pop only raises it after its own edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            inReady_q <= 1'b0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                memI_q[e] <= '0;
                memQ_q[e] <= '0;
            end
        end else begin
            if (push) begin
                memI_q[wrPtr_q] <= in_i;
                memQ_q[wrPtr_q] <= in_q;
                wrPtr_q         <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            inReady_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            pI_q       <= '0;
            nI_q       <= '0;
            pQ_q       <= '0;
            nQ_q       <= '0;
            outI_q     <= '0;
            outQ_q     <= '0;
            outValid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        pI_q    <= headI;
                        pQ_q    <= headQ;
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    if (pop) begin
                        nI_q    <= headI;
                        nQ_q    <= headQ;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    outI_q     <= interp(pI_q, nI_q, k_q);
                    outQ_q     <= interp(pQ_q, nQ_q, k_q);
                    outValid_q <= 1'b1;
                    k_q        <= k_q + RATIO_LOG2'(1);
                    // On an empty wrap N is held, so the next interval is flat.
                    if (&k_q) begin
                        pI_q <= nI_q;
                        pQ_q <= nQ_q;
                        if (pop) begin
                            nI_q <= headI;
                            nQ_q <= headQ;
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_i     = outI_q;
    assign out_q     = outQ_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_iq_interp.sv
// tb_iq_interp: directed vector bench for iq_interp (ramp, slopes, rounding, FIFO fill, underrun, reset).
`timescale 1ns/1ps

module tb_iq_interp;

    localparam int DATA_W = 10;
    localparam int R      = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_i = '0;
    logic [DATA_W-1:0] in_q = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;
    logic              underrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    pI;
        int    nI;
        int    pQ;
        int    nQ;
        int    expI[8];
        int    expQ[8];
    } vec_t;

    vec_t vecs[4];

    iq_interp #(.DATA_W(DATA_W), .RATIO_LOG2(3), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .underrun  (underrun)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one sample and holds it until the handshake completes on an edge.
    task automatic applyStimulus(input int i, input int q);
        bit accepted;
        accepted = 1'b0;
        in_i     = DATA_W'(i);
        in_q     = DATA_W'(q);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        checkOutput("push_accept", int'(accepted), 1);
    endtask

    task automatic waitValid();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("valid_rise", int'(seen), 1);
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        reset    = 1'b1;
        #12;
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_out_i"}, int'(out_i), 0);
        checkOutput({tag, "_out_q"}, int'(out_q), 0);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        int  t;
        int  expI;
        bit  prevReady;
        int  s;

        vecs[0].name = "ramp";
        vecs[0].pI = 0;    vecs[0].nI = 80;   vecs[0].pQ = 0;    vecs[0].nQ = -80;
        vecs[0].expI = '{0, 10, 20, 30, 40, 50, 60, 70};
        vecs[0].expQ = '{0, -10, -20, -30, -40, -50, -60, -70};

        vecs[1].name = "negslope";
        vecs[1].pI = 100;  vecs[1].nI = -100; vecs[1].pQ = -100; vecs[1].nQ = 100;
        vecs[1].expI = '{100, 75, 50, 25, 0, -25, -50, -75};
        vecs[1].expQ = '{-100, -75, -50, -25, 0, 25, 50, 75};

        vecs[2].name = "rounding";
        vecs[2].pI = 0;    vecs[2].nI = 5;    vecs[2].pQ = 0;    vecs[2].nQ = -5;
        vecs[3].name = "extremes";
        vecs[3].pI = -512; vecs[3].nI = 511;  vecs[3].pQ = 511;  vecs[3].nQ = -512;
`ifdef IQ_INTERP_ROUND_EN
        vecs[2].expI = '{0, 1, 1, 2, 3, 3, 4, 4};
        vecs[2].expQ = '{0, -1, -1, -2, -2, -3, -4, -4};
        vecs[3].expI = '{-512, -384, -256, -128, 0, 127, 255, 383};
        vecs[3].expQ = '{511, 383, 255, 127, 0, -128, -256, -384};
`else
        vecs[2].expI = '{0, 0, 1, 1, 2, 3, 3, 4};
        vecs[2].expQ = '{0, -1, -2, -2, -3, -4, -4, -5};
        vecs[3].expI = '{-512, -385, -257, -129, -1, 127, 255, 383};
        vecs[3].expQ = '{511, 383, 255, 127, -1, -129, -257, -385};
`endif

        #3;
        checkResetValues("por");
        @(negedge clock);
        reset = 1'b0;
        tick();
        checkOutput("por_ready_first_edge", int'(in_ready), 1);

        // Table: P, N, N gives one interpolated interval followed by a flat interval at N.
        foreach (vecs[v]) begin
            doReset();
            applyStimulus(vecs[v].pI, vecs[v].pQ);
            applyStimulus(vecs[v].nI, vecs[v].nQ);
            applyStimulus(vecs[v].nI, vecs[v].nQ);
            waitValid();
            checkOutput($sformatf("%s_underrun", vecs[v].name), int'(underrun), 0);
            for (int k = 0; k < R; k++) begin
                checkOutput($sformatf("%s_i_k%0d", vecs[v].name, k), int'($signed(out_i)), vecs[v].expI[k]);
                checkOutput($sformatf("%s_q_k%0d", vecs[v].name, k), int'($signed(out_q)), vecs[v].expQ[k]);
                tick();
            end
            for (int k = 0; k < R; k++) begin
                checkOutput($sformatf("%s_flat_i_k%0d", vecs[v].name, k), int'($signed(out_i)), vecs[v].nI);
                checkOutput($sformatf("%s_flat_q_k%0d", vecs[v].name, k), int'($signed(out_q)), vecs[v].nQ);
                tick();
            end
        end

        // Continuous input: sample s carries 16*s, so a lossless stream reads 2*t on I and -2*t on Q.
        doReset();
        s         = 0;
        t         = 0;
        in_i      = '0;
        in_q      = '0;
        in_valid  = 1'b1;
        prevReady = in_ready;
        for (int c = 0; c < 200 && t < 40; c++) begin
            tick();
            if (prevReady) begin
                s++;
                in_i = DATA_W'(16 * s);
                in_q = DATA_W'(-16 * s);
            end
            prevReady = in_ready;
            if (out_valid) begin
                checkOutput($sformatf("stream_i_t%0d", t), int'($signed(out_i)), 2 * t);
                checkOutput($sformatf("stream_q_t%0d", t), int'($signed(out_q)), -2 * t);
                if (t == 5) checkOutput("fifo_full_ready", int'(in_ready), 0);
                if (t == 6) checkOutput("wrap_cycle_ready", int'(in_ready), 0);
                if (t == 7) checkOutput("after_pop_ready", int'(in_ready), 1);
                t++;
            end
        end
        in_valid = 1'b0;
        checkOutput("stream_length", t, 40);
        checkOutput("stream_underrun", int'(underrun), 0);

        // Underrun: prime with 0 and 80, then starve; a late push of 160 resumes at the next wrap.
        doReset();
        applyStimulus(0, 0);
        applyStimulus(80, 0);
        waitValid();
        for (int u = 0; u < 24; u++) begin
            if (u < 8)       expI = 10 * u;
            else if (u < 16) expI = 80;
            else             expI = 80 + 10 * (u - 16);
            checkOutput($sformatf("underrun_i_t%0d", u), int'($signed(out_i)), expI);
            checkOutput($sformatf("underrun_flag_t%0d", u), int'(underrun), (u < 7) ? 0 : 1);
            if (u == 10) begin
                in_i     = DATA_W'(160);
                in_q     = '0;
                in_valid = 1'b1;
            end
            if (u == 11) in_valid = 1'b0;
            tick();
        end

        // Asynchronous reset between edges while running.
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("async");
        #3;
        reset = 1'b0;
        tick();
        checkOutput("async_ready_first_edge", int'(in_ready), 1);
        checkOutput("async_valid_idle", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
